// File: rtl/frame_tx_packer.sv
// Output framer: 4-byte H/W header then H*W pixel bytes from a small FIFO, paced on tx_done.
// Optional XOR trailer byte when FRAME_CHECKSUM_EN is defined.
module frame_tx_packer #(
  parameter int FIFO_AW = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [15:0]        H,
  input  logic [15:0]        W,
  input  logic [7:0]         pix_data,
  input  logic               pix_valid,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_done,
  output logic               busy,
  output logic               frame_done,
  output logic               overflow,
  output logic [FIFO_AW:0]   fifo_level
);
  localparam int unsigned DEPTH = 2**FIFO_AW;
  localparam logic [FIFO_AW:0] LVL_FULL = (FIFO_AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE, HDR_SEND, HDR_WAIT, PIX_POP, PIX_WAIT,
`ifdef FRAME_CHECKSUM_EN
    CHK_SEND, CHK_WAIT,
`endif
    DONE
  } state_e;

`ifdef FRAME_CHECKSUM_EN
  localparam state_e BODY_END = CHK_SEND;
`else
  localparam state_e BODY_END = DONE;
`endif

  state_e               state_q, state_d;
  logic [15:0]          h_q, h_d, w_q, w_d;
  logic [31:0]          total_q, total_d, pix_cnt_q, pix_cnt_d, acc_cnt_q, acc_cnt_d;
  logic [1:0]           hdr_idx_q, hdr_idx_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 tx_valid_q, tx_valid_d, busy_q, busy_d;
  logic                 frame_done_q, frame_done_d, overflow_q, overflow_d;
  logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]     level_q, level_d;
  logic [7:0]           mem_q [DEPTH];
  logic [7:0]           hdr_byte;
  logic                 pop, push_req, push_ok, accept;
`ifdef FRAME_CHECKSUM_EN
  logic [7:0]           chk_q, chk_d;
`endif

  always_comb begin
    hdr_byte = 8'd0;
    case (hdr_idx_q)
      2'd0: hdr_byte = h_q[15:8];
      2'd1: hdr_byte = h_q[7:0];
      2'd2: hdr_byte = w_q[15:8];
      default: hdr_byte = w_q[7:0];
    endcase
  end

  always_comb begin
    state_d      = state_q;
    h_d          = h_q;
    w_d          = w_q;
    total_d      = total_q;
    pix_cnt_d    = pix_cnt_q;
    acc_cnt_d    = acc_cnt_q;
    hdr_idx_d    = hdr_idx_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = 1'b0;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    overflow_d   = overflow_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    pop          = 1'b0;
    push_req     = 1'b0;
    push_ok      = 1'b0;
    accept       = 1'b0;
`ifdef FRAME_CHECKSUM_EN
    chk_d        = chk_q;
`endif

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          accept     = 1'b1;
          h_d        = H;
          w_d        = W;
          total_d    = {16'd0, H} * {16'd0, W};
          pix_cnt_d  = '0;
          acc_cnt_d  = '0;
          hdr_idx_d  = '0;
          overflow_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = HDR_SEND;
        end
      end
      HDR_SEND: begin
        tx_data_d  = hdr_byte;
        tx_valid_d = 1'b1;
        state_d    = HDR_WAIT;
      end
      HDR_WAIT: if (tx_done) begin
        if (hdr_idx_q == 2'd3) state_d = (total_q == '0) ? BODY_END : PIX_POP;
        else begin
          hdr_idx_d = hdr_idx_q + 2'd1;
          state_d   = HDR_SEND;
        end
      end
      // Stalls indefinitely if pixels were lost; reset is the only way out.
      PIX_POP: if (level_q != '0) begin
        pop        = 1'b1;
        tx_data_d  = mem_q[rd_ptr_q];
        tx_valid_d = 1'b1;
        state_d    = PIX_WAIT;
      end
      PIX_WAIT: if (tx_done) begin
        pix_cnt_d = pix_cnt_q + 32'd1;
        state_d   = (pix_cnt_d == total_q) ? BODY_END : PIX_POP;
      end
`ifdef FRAME_CHECKSUM_EN
      CHK_SEND: begin
        tx_data_d  = chk_q;
        tx_valid_d = 1'b1;
        state_d    = CHK_WAIT;
      end
      CHK_WAIT: if (tx_done) state_d = DONE;
`endif
      default: state_d = IDLE;
    endcase

    if (state_d == DONE && state_q != DONE) begin
      frame_done_d = 1'b1;
      busy_d       = 1'b0;
    end

`ifdef FRAME_CHECKSUM_EN
    if (accept) chk_d = 8'd0;
    else if (tx_valid_d && state_q != CHK_SEND) chk_d = chk_q ^ tx_data_d;
`endif

    // acc_cnt counts attempts, so a dropped pixel still uses up its slot.
    push_req = pix_valid && busy_q && (acc_cnt_q < total_q);
    push_ok  = push_req && ((level_q != LVL_FULL) || pop);
    if (push_req) acc_cnt_d = acc_cnt_q + 32'd1;
    if (push_req && !push_ok) overflow_d = 1'b1;
    if (push_ok) wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
    case ({push_ok, pop})
      2'b10:   level_d = level_q + (FIFO_AW+1)'(1);
      2'b01:   level_d = level_q - (FIFO_AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      h_q          <= '0;
      w_q          <= '0;
      total_q      <= '0;
      pix_cnt_q    <= '0;
      acc_cnt_q    <= '0;
      hdr_idx_q    <= '0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
`ifdef FRAME_CHECKSUM_EN
      chk_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      h_q          <= h_d;
      w_q          <= w_d;
      total_q      <= total_d;
      pix_cnt_q    <= pix_cnt_d;
      acc_cnt_q    <= acc_cnt_d;
      hdr_idx_q    <= hdr_idx_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
`ifdef FRAME_CHECKSUM_EN
      chk_q        <= chk_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= pix_data;
  end

  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;
  assign fifo_level = level_q;
endmodule

// File: tb/tb_frame_tx_packer.sv
// Bench for frame_tx_packer: directed + randomized frames against a byte-list reference model;
// transmitter modelled with tx_done 10 cycles after each tx_valid.
module tb_frame_tx_packer;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n, start, pix_valid, tx_done;
  logic [15:0]   H, W;
  logic [7:0]    pix_data, tx_data;
  logic          tx_valid, busy, frame_done, overflow;
  logic [AW:0]   fifo_level;

  int checks = 0, failures = 0;
  logic [7:0] got_q[$];
  int fd_cnt = 0, max_lvl = 0, cnt = 0;
  logic [7:0] last_b = 8'd0;

  always #5 clk = ~clk;

  frame_tx_packer #(.FIFO_AW(AW)) dut (
    .clk(clk), .reset(rst_n), .start(start), .H(H), .W(W),
    .pix_data(pix_data), .pix_valid(pix_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_done(tx_done),
    .busy(busy), .frame_done(frame_done), .overflow(overflow), .fifo_level(fifo_level)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Transmitter model and byte monitor.
  always @(negedge clk) begin
    logic pending;
    tx_done = 1'b0;
    if (!rst_n) cnt = 0;
    else begin
      pending = (cnt > 0);
      if (cnt > 0) begin
        chk("tx_hold", 32'(tx_data), 32'(last_b));
        cnt--;
        if (cnt == 0) tx_done = 1'b1;
      end
      if (tx_valid) begin
        chk("tx_pace", 32'(pending), 32'd0);
        got_q.push_back(tx_data);
        last_b = tx_data;
        cnt = 10;
      end
      if (frame_done) begin
        fd_cnt++;
        chk("fd_busy", 32'(busy), 32'd0);
      end
    end
    if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
  end

  function automatic void build_exp(input logic [15:0] h, input logic [15:0] w,
                                    input logic [7:0] px[$], output logic [7:0] e[$]);
    longint total = longint'(h) * longint'(w);
    e = {};
    e.push_back(h[15:8]); e.push_back(h[7:0]);
    e.push_back(w[15:8]); e.push_back(w[7:0]);
    for (int i = 0; i < total; i++) e.push_back(px[i]);
`ifdef FRAME_CHECKSUM_EN
    begin
      logic [7:0] x = 8'd0;
      foreach (e[i]) x ^= e[i];
      e.push_back(x);
    end
`endif
  endfunction

  task automatic check_reset_vals(input string tag);
    chk({tag, "_tx_data"},  32'(tx_data), 32'd0);
    chk({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
    chk({tag, "_busy"},     32'(busy), 32'd0);
    chk({tag, "_fdone"},    32'(frame_done), 32'd0);
    chk({tag, "_ovf"},      32'(overflow), 32'd0);
    chk({tag, "_level"},    32'(fifo_level), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; pix_valid = 1'b0; pix_data = 8'd0; H = '0; W = '0;
    repeat (3) @(posedge clk);
    #1 check_reset_vals("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic pulse_start(input logic [15:0] h, input logic [15:0] w);
    @(posedge clk); #1;
    H = h; W = w; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drive_pix(input logic [7:0] px[$], input int burst);
    foreach (px[i]) begin
      pix_data = px[i]; pix_valid = 1'b1;
      @(posedge clk); #1;
      pix_valid = 1'b0;
      if (i >= burst - 1)
        repeat ($urandom_range(12, 14)) begin @(posedge clk); #1; end
    end
    // Extra pixels beyond the frame count must be discarded.
    repeat (3) begin
      pix_data = 8'($urandom); pix_valid = 1'b1;
      @(posedge clk); #1;
    end
    pix_valid = 1'b0;
  endtask

  task automatic wait_frame(input int budget);
    int n = 0;
    while (fd_cnt == 0 && n < budget) begin @(posedge clk); n++; end
    chk("frame_done_seen", 32'(fd_cnt > 0), 32'd1);
  endtask

  task automatic run_frame(input string tag, input logic [15:0] h, input logic [15:0] w,
                           input logic [7:0] px[$], input int burst, input bit restart);
    logic [7:0] e[$];
    int total = int'(h) * int'(w);
    got_q = {}; fd_cnt = 0; max_lvl = 0;
    pulse_start(h, w);
    fork
      drive_pix(px, burst);
      wait_frame(300 + (total + 6) * 30);
      if (restart) begin
        repeat (12) @(posedge clk);
        #1 H = ~h; W = ~w; start = 1'b1;
        @(posedge clk); #1 start = 1'b0; H = h; W = w;
      end
    join
    repeat (4) @(posedge clk);
    #1;
    build_exp(h, w, px, e);
    chk({tag, "_len"}, 32'(got_q.size()), 32'(e.size()));
    foreach (e[i])
      if (i < got_q.size()) chk($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(e[i]));
    chk({tag, "_fd_once"}, 32'(fd_cnt), 32'd1);
    chk({tag, "_ovf"},     32'(overflow), 32'd0);
    chk({tag, "_busy"},    32'(busy), 32'd0);
    chk({tag, "_level"},   32'(fifo_level), 32'd0);
  endtask

  initial begin
    logic [7:0] px[$];
    int n;

    do_reset();

    // Spec example: 2x3 frame, pixels arrive during the header.
    px = {8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
    run_frame("f2x3", 16'd2, 16'd3, px, 6, 1'b0);

    // Zero-size frame: header only, pixels ignored.
    px = {8'hde, 8'had, 8'hbe};
    run_frame("f0x5", 16'd0, 16'd5, px, 3, 1'b0);

    // Restart attempt mid-header is ignored.
    px = {8'h21, 8'h22, 8'h23, 8'h24};
    run_frame("restart", 16'd2, 16'd2, px, 4, 1'b1);

    // Checksum example frame (trailer expected only with the macro).
    px = {8'haa, 8'h55};
    run_frame("f1x2", 16'd1, 16'd2, px, 2, 1'b0);

    // Randomized frames.
    for (int k = 0; k < 4; k++) begin
      logic [15:0] h, w;
      h = 16'($urandom_range(0, 4));
      w = 16'($urandom_range(0, 5));
      px = {};
      for (int i = 0; i < int'(h) * int'(w); i++) px.push_back(8'($urandom));
      run_frame($sformatf("rnd%0d", k), h, w, px, $urandom_range(1, 10), 1'b0);
    end

    // Overflow: 20 back-to-back pixels into a 16-deep FIFO during the header.
    px = {};
    for (int i = 0; i < 20; i++) px.push_back(8'($urandom));
    got_q = {}; fd_cnt = 0; max_lvl = 0;
    pulse_start(16'd1, 16'd20);
    drive_pix(px, 20);
    n = 0;
    while (got_q.size() < 20 && n < 800) begin @(posedge clk); n++; end
    repeat (60) @(posedge clk);
    #1;
    chk("ovf_len", 32'(got_q.size()), 32'd20);
    for (int i = 0; i < 16; i++)
      if (4 + i < got_q.size()) chk($sformatf("ovf_pix%0d", i), 32'(got_q[4+i]), 32'(px[i]));
    chk("ovf_flag",  32'(overflow), 32'd1);
    chk("ovf_peak",  32'(max_lvl), 32'd16);
    chk("ovf_stall", 32'(fd_cnt), 32'd0);
    chk("ovf_busy",  32'(busy), 32'd1);
    chk("ovf_level", 32'(fifo_level), 32'd0);
    do_reset();

    // Asynchronous reset while waiting on a pixel byte.
    got_q = {}; fd_cnt = 0;
    px = {8'h31, 8'h32, 8'h33, 8'h34};
    pulse_start(16'd1, 16'd4);
    drive_pix(px, 4);
    n = 0;
    while (got_q.size() < 5 && n < 400) begin @(negedge clk); n++; end
    chk("ar_reached", 32'(got_q.size()), 32'd5);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("arst");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1 chk("ar_no_resume", 32'(got_q.size()), 32'd5);
    px = {8'h41, 8'h42, 8'h43, 8'h44};
    run_frame("post_rst", 16'd1, 16'd4, px, 4, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
